rr8_decode_arbiter: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters and drives the 3-bit owner index through a 3-to-8 one-hot decode stage to produce per-requester grant lines. It sits between eight request sources and the shared resource. It holds each grant until the owner releases, drops its request, or exceeds a hold limit. A one-cycle dead gap between owners guarantees no two grant lines are ever high together.

---
 rtl/rr8_decode_arbiter.sv | 94 +++++++++
 tb/tb_rr8_decode_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr8_decode_arbiter.sv
// Eight-way round-robin arbiter with hold limit and a one-cycle dead gap between owners.
// The registered owner index feeds a plain 3-to-8 decode to form the one-hot grant lines.
module rr8_decode_arbiter #(
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  state_t            state_q;
  logic [2:0]        ptr_q;
  logic [2:0]        idx_q;
  logic              valid_q;
  logic              timeout_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  logic [2:0] win_idx;
  logic       rel_done;
  logic       rel_drop;
  logic       rel_limit;

  // Scan from farthest to nearest so the nearest set bit after ptr wins; ptr itself is last.
  always_comb begin
    win_idx = ptr_q;
    for (int k = 8; k >= 1; k--) begin
      if (req[ptr_q + 3'(k)]) begin
        win_idx = ptr_q + 3'(k);
      end
    end
  end

  assign rel_done  = done;
  assign rel_drop  = ~req[idx_q];
  assign rel_limit = (hold_q == HOLD_W'(MAX_HOLD - 1));
  assign hold_d    = hold_q + HOLD_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd7;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        BUSY: begin
          if (rel_done || rel_drop || rel_limit) begin
            state_q   <= GAP;
            valid_q   <= 1'b0;
            timeout_q <= rel_limit & ~rel_done & ~rel_drop;
          end else begin
            hold_q    <= hold_d;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          timeout_q <= 1'b0;
          if (req != 8'h00) begin
            state_q <= BUSY;
            idx_q   <= win_idx;
            ptr_q   <= win_idx;
            valid_q <= 1'b1;
            hold_q  <= '0;
          end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_decode
      assign grant[gi] = valid_q & (idx_q == 3'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_rr8_decode_arbiter.sv
// Self-checking bench for rr8_decode_arbiter: vector table, directed corner sequences,
// and a randomized run against a behavioural model of the round-robin rules.
module tb_rr8_decode_arbiter;

  localparam int MAXH = 4;
  localparam int NVEC = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int n_checks = 0;
  int n_pass = 0;

  rr8_decode_arbiter #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       done;
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } vec_t;

  vec_t vec [NVEC];

  // Behavioural model: "owner or nobody", with a gap flag after each release.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_to;

  function automatic logic [12:0] pack(input logic [7:0] g, input logic [2:0] i,
                                       input logic v, input logic t);
    return {g, i, v, t};
  endfunction

  function automatic logic [12:0] model_exp();
    logic [7:0] g;
    g = m_busy ? 8'(1 << m_owner) : 8'h00;
    return pack(g, 3'(m_owner), m_busy, m_to);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 7; m_held = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    if (!m_busy) begin
      m_to = 0;
      for (int k = 1; k <= 8; k++) begin
        if (r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          m_ptr = m_owner;
          m_busy = 1;
          m_held = 1;
          break;
        end
      end
    end else begin
      bit rel_a, rel_b, rel_c;
      rel_a = d;
      rel_b = !r[m_owner];
      rel_c = (m_held == MAXH);
      if (rel_a || rel_b || rel_c) begin
        m_busy = 0;
        m_to = rel_c && !rel_a && !rel_b;
      end else begin
        m_held++;
        m_to = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {grant, grant_idx, grant_valid, timeout};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got grant=%h idx=%0d valid=%b timeout=%b, expected grant=%h idx=%0d valid=%b timeout=%b",
                  name, act[12:5], act[4:2], act[1], act[0], exp[12:5], exp[4:2], exp[1], exp[0]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 8'h00;
    done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", pack(8'h00, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    vec[0]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vec[1]  = '{8'h81, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
    vec[2]  = '{8'h81, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0};
    vec[3]  = '{8'h81, 1'b1, 8'h00, 3'd7, 1'b0, 1'b0};
    vec[4]  = '{8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
    vec[5]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vec[6]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vec[7]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vec[8]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vec[9]  = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vec[10] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vec[11] = '{8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 1'b1};
    vec[12] = '{8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 1'b0};
    vec[13] = '{8'h04, 1'b1, 8'h00, 3'd2, 1'b0, 1'b0};
    vec[14] = '{8'h00, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0};
    vec[15] = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[16] = '{8'h28, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
    vec[17] = '{8'h20, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0};
    vec[18] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vec[19] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vec[20] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vec[21] = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
    vec[22] = '{8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
    vec[23] = '{8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};

    // Vector table: 81 alternation, hold-limit timeout, request drop, done at the limit.
    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      req = vec[i].req;
      done = vec[i].done;
      step();
      check($sformatf("vec%0d", i), pack(vec[i].grant, vec[i].idx, vec[i].valid, vec[i].to));
    end

    // All eight requesting, done one cycle after each grant: index walks 0..7,0.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k <= 8; k++) begin
      done = 1'b0;
      step();
      check($sformatf("ff_grant%0d", k), pack(8'(1 << (k % 8)), 3'(k % 8), 1'b1, 1'b0));
      done = 1'b1;
      step();
      check($sformatf("ff_gap%0d", k), pack(8'h00, 3'(k % 8), 1'b0, 1'b0));
    end
    done = 1'b0;

    // Asynchronous reset while idx 6 owns the grant, then 0 wins over 6.
    do_reset();
    req = 8'h40;
    step();
    check("own6", pack(8'h40, 3'd6, 1'b1, 1'b0));
    #2 rst_n = 1'b0;
    #1 check("async_reset_drop", pack(8'h00, 3'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    req = 8'h41;
    step();
    check("post_reset_grant", pack(8'h01, 3'd0, 1'b1, 1'b0));

    // Randomized run against the model, with one asynchronous reset in the middle.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 8'($urandom);
      if ($urandom_range(0, 9) == 0) req = 8'h00;
      done = ($urandom_range(0, 5) == 0);
      step();
      model_edge(req, done);
      check($sformatf("rand%0d", i), model_exp());
      if (i == 300) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rand_async_reset", model_exp());
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
